// File: rtl/craps_pkg.sv
// Shared types, rule constants and display helpers for the craps controller.
package craps_pkg;

    typedef enum logic [2:0] {
        ST_READY = 3'd0,
        ST_EVAL  = 3'd1,
        ST_POINT = 3'd2,
        ST_WIN   = 3'd3,
        ST_LOSE  = 3'd4
    } state_t;

    localparam logic [3:0] SUM_SEVEN        = 4'd7;
    localparam logic [3:0] SUM_ELEVEN       = 4'd11;
    localparam logic [3:0] SUM_CRAPS_TWO    = 4'd2;
    localparam logic [3:0] SUM_CRAPS_THREE  = 4'd3;
    localparam logic [3:0] SUM_CRAPS_TWELVE = 4'd12;

    localparam logic [2:0] DIE_MAX = 3'd6;

    // Split a dice sum (or point) in 0..12 into {tens, ones} BCD nibbles.
    function automatic logic [7:0] bcd_split(input logic [3:0] value);
        logic [7:0] result;
        if (value >= 4'd10) begin
            result = {4'd1, value - 4'd10};
        end else begin
            result = {4'd0, value};
        end
        return result;
    endfunction

endpackage

// File: rtl/dice_counter.sv
// Two chained free-running 1..6 counters; the second advances when the first wraps.
module dice_counter
    import craps_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    output logic [2:0] die1,
    output logic [2:0] die2
);

    // die1 steps every clock; die2 steps on die1's 6 -> 1 wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            die1 <= 3'd1;
            die2 <= 3'd1;
        end else if (die1 == DIE_MAX) begin
            die1 <= 3'd1;
            die2 <= (die2 == DIE_MAX) ? 3'd1 : die2 + 3'd1;
        end else begin
            die1 <= die1 + 3'd1;
        end
    end

endmodule

// File: rtl/craps_ctrl.sv
// Craps round sequencer: captures the dice on a roll, scores it, tracks the
// point and drives the registered LED and display outputs.
module craps_ctrl
    import craps_pkg::*;
(
    input  logic        Clk100MHz,
    input  logic        reset_n,
    input  logic        Clk1HzEn,
    input  logic        RollPulse,
    output logic [31:0] Data,
    output logic [7:0]  XDP,
    output logic        RollDiceLed,
    output logic        PlayerWinsLed,
    output logic        PlayerLosesLed
);

    logic [2:0] die1;
    logic [2:0] die2;
    state_t     state;
    logic [2:0] d1q;
    logic [2:0] d2q;
    logic       first_roll;
    logic [3:0] point;
    logic [3:0] sum;
    state_t     eval_state;
    logic [3:0] eval_point;

    dice_counter u_dice (
        .clk   (Clk100MHz),
        .rst_n (reset_n),
        .die1  (die1),
        .die2  (die2)
    );

    assign sum = {1'b0, d1q} + {1'b0, d2q};

    // Score the captured roll: outcome state and the point value that follows it.
    always_comb begin
        eval_state = ST_POINT;
        eval_point = point;
        if (first_roll) begin
            if (sum == SUM_SEVEN || sum == SUM_ELEVEN) begin
                eval_state = ST_WIN;
                eval_point = 4'd0;
            end else if (sum == SUM_CRAPS_TWO || sum == SUM_CRAPS_THREE ||
                         sum == SUM_CRAPS_TWELVE) begin
                eval_state = ST_LOSE;
                eval_point = 4'd0;
            end else begin
                eval_state = ST_POINT;
                eval_point = sum;
            end
        end else begin
            if (sum == point) begin
                eval_state = ST_WIN;
                eval_point = 4'd0;
            end else if (sum == SUM_SEVEN) begin
                eval_state = ST_LOSE;
                eval_point = 4'd0;
            end else begin
                eval_state = ST_POINT;
                eval_point = point;
            end
        end
    end

    // Round FSM with capture, point and output registers; outputs follow the next state.
    always_ff @(posedge Clk100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_READY;
            d1q            <= 3'd0;
            d2q            <= 3'd0;
            first_roll     <= 1'b1;
            point          <= 4'd0;
            Data           <= 32'd0;
            XDP            <= 8'd0;
            RollDiceLed    <= 1'b1;
            PlayerWinsLed  <= 1'b0;
            PlayerLosesLed <= 1'b0;
        end else begin
            case (state)
                ST_READY, ST_POINT, ST_WIN, ST_LOSE: begin
                    if (RollPulse) begin
                        // A roll takes priority over a blink tick and clears the LEDs.
                        d1q            <= die1;
                        d2q            <= die2;
                        first_roll     <= (state != ST_POINT);
                        state          <= ST_EVAL;
                        XDP            <= 8'd0;
                        RollDiceLed    <= 1'b0;
                        PlayerWinsLed  <= 1'b0;
                        PlayerLosesLed <= 1'b0;
                    end else if (Clk1HzEn) begin
                        if (state == ST_WIN) begin
                            PlayerWinsLed <= ~PlayerWinsLed;
                        end
                        if (state == ST_LOSE) begin
                            PlayerLosesLed <= ~PlayerLosesLed;
                        end
                    end
                end
                ST_EVAL: begin
                    // Blink ticks are not looked at here, so a result LED always enters on.
                    state          <= eval_state;
                    point          <= eval_point;
                    Data           <= {8'h00, 1'b0, d2q, 1'b0, d1q,
                                       bcd_split(eval_point), bcd_split(sum)};
                    XDP            <= {7'd0, eval_state == ST_POINT};
                    RollDiceLed    <= (eval_state == ST_POINT);
                    PlayerWinsLed  <= (eval_state == ST_WIN);
                    PlayerLosesLed <= (eval_state == ST_LOSE);
                end
                default: begin
                    state <= ST_READY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_craps_ctrl.sv
// Directed bench for craps_ctrl with a scoreboard of expected round results.
module tb_craps_ctrl;
    import craps_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        Clk1HzEn;
    logic        RollPulse;
    logic [31:0] Data;
    logic [7:0]  XDP;
    logic        RollDiceLed;
    logic        PlayerWinsLed;
    logic        PlayerLosesLed;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  xdp;
        logic        rled;
        logic        wled;
        logic        lled;
    } exp_t;

    exp_t sb[$];

    bit m_first = 1'b1;
    int m_point = 0;

    craps_ctrl dut (
        .Clk100MHz      (clk),
        .reset_n        (reset_n),
        .Clk1HzEn       (Clk1HzEn),
        .RollPulse      (RollPulse),
        .Data           (Data),
        .XDP            (XDP),
        .RollDiceLed    (RollDiceLed),
        .PlayerWinsLed  (PlayerWinsLed),
        .PlayerLosesLed (PlayerLosesLed)
    );

    always #5 clk = ~clk;

    // Edges seen since reset release; the dice are a pure function of this count.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic int die1_at(input int c);
        return 1 + (c % 6);
    endfunction

    function automatic int die2_at(input int c);
        return 1 + ((c / 6) % 6);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        tests++;
        assert (sb.size() > 0) else begin
            fails++;
            $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_data"}, Data, e.data);
            check({tag, "_xdp"}, 32'(XDP), 32'(e.xdp));
            check({tag, "_rled"}, 32'(RollDiceLed), 32'(e.rled));
            check({tag, "_wled"}, 32'(PlayerWinsLed), 32'(e.wled));
            check({tag, "_lled"}, 32'(PlayerLosesLed), 32'(e.lled));
        end
    endtask

    // Wait for the requested dice, pulse a roll, predict the result and check it at N+2.
    task automatic roll(input int d1, input int d2, input bit en_with_roll,
                        input bit en_in_eval, input bit pulse_in_eval, input string tag);
        bit   found;
        int   sum;
        int   outcome;
        exp_t e;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (die1_at(cyc) == d1 && die2_at(cyc) == d2) begin
                found = 1'b1;
                break;
            end
        end
        tests++;
        assert (found) else begin
            fails++;
            $error("FAIL %s_wait: observed no %0d/%0d within bound expected dice reached", tag, d1, d2);
        end
        if (found) begin
            sum = d1 + d2;
            if (m_first) begin
                if (sum == 7 || sum == 11) outcome = 1;
                else if (sum == 2 || sum == 3 || sum == 12) outcome = 2;
                else begin
                    outcome = 0;
                    m_point = sum;
                end
            end else begin
                if (sum == m_point) outcome = 1;
                else if (sum == 7) outcome = 2;
                else outcome = 0;
            end
            if (outcome != 0) m_point = 0;
            m_first = (outcome != 0);
            e.data = {8'h00, 4'(d2), 4'(d1), to_bcd(m_point), to_bcd(sum)};
            e.xdp  = (outcome == 0) ? 8'h01 : 8'h00;
            e.rled = (outcome == 0);
            e.wled = (outcome == 1);
            e.lled = (outcome == 2);
            sb.push_back(e);

            RollPulse = 1'b1;
            Clk1HzEn  = en_with_roll;
            @(negedge clk);
            RollPulse = pulse_in_eval;
            Clk1HzEn  = en_in_eval;
            check({tag, "_eval_state"}, 32'(dut.state), 32'(ST_EVAL));
            check({tag, "_eval_d1q"}, 32'(dut.d1q), 32'(d1));
            check({tag, "_eval_d2q"}, 32'(dut.d2q), 32'(d2));
            check({tag, "_eval_rled"}, 32'(RollDiceLed), 32'd0);
            @(negedge clk);
            RollPulse = 1'b0;
            Clk1HzEn  = 1'b0;
            compare_out(tag);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, Data, 32'd0);
        check({tag, "_xdp"}, 32'(XDP), 32'd0);
        check({tag, "_rled"}, 32'(RollDiceLed), 32'd1);
        check({tag, "_wled"}, 32'(PlayerWinsLed), 32'd0);
        check({tag, "_lled"}, 32'(PlayerLosesLed), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected end of run");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n   = 1'b0;
        Clk1HzEn  = 1'b0;
        RollPulse = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        check("reset_die1", 32'(dut.die1), 32'd1);
        check("reset_die2", 32'(dut.die2), 32'd1);
        check("reset_state", 32'(dut.state), 32'(ST_READY));
        reset_n = 1'b1;
        repeat (7) @(negedge clk);
        check("c7_cyc", 32'(cyc), 32'd7);
        check("c7_die1", 32'(dut.die1), 32'd2);
        check("c7_die2", 32'(dut.die2), 32'd2);
        check_reset_outputs("ready_idle");

        // Natural win on 3/4, then blink
        roll(3, 4, 1'b0, 1'b0, 1'b0, "natural_win");
        @(negedge clk);
        Clk1HzEn = 1'b1;
        @(negedge clk);
        Clk1HzEn = 1'b0;
        check("win_blink_off", 32'(PlayerWinsLed), 32'd0);
        check("win_blink_data", Data, 32'h00430007);
        @(negedge clk);
        Clk1HzEn = 1'b1;
        @(negedge clk);
        Clk1HzEn = 1'b0;
        check("win_blink_on", 32'(PlayerWinsLed), 32'd1);

        // Craps loss on 6/6; blink ticks with the roll and in EVAL are ignored
        roll(6, 6, 1'b1, 1'b1, 1'b0, "craps_loss");
        check("craps_loss_point", 32'(dut.point), 32'd0);

        // Point made
        roll(2, 2, 1'b0, 1'b0, 1'b0, "point4");
        roll(1, 5, 1'b0, 1'b0, 1'b0, "point_miss");
        roll(1, 3, 1'b0, 1'b0, 1'b0, "point_made");

        // Seven-out with a pulse in EVAL, then a fresh first roll
        roll(4, 5, 1'b0, 1'b0, 1'b1, "point9");
        @(negedge clk);
        check("point9_hold_state", 32'(dut.state), 32'(ST_POINT));
        check("point9_hold_rled", 32'(RollDiceLed), 32'd1);
        roll(2, 5, 1'b0, 1'b0, 1'b0, "seven_out");
        roll(5, 6, 1'b0, 1'b0, 1'b0, "first_after_loss");

        // Reset in the EVAL cycle
        @(negedge clk);
        RollPulse = 1'b1;
        @(negedge clk);
        RollPulse = 1'b0;
        check("mid_eval_state", 32'(dut.state), 32'(ST_EVAL));
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid_eval_rst");
        check("mid_eval_rst_state", 32'(dut.state), 32'(ST_READY));
        check("mid_eval_rst_d1q", 32'(dut.d1q), 32'd0);
        check("mid_eval_rst_d2q", 32'(dut.d2q), 32'd0);
        check("mid_eval_rst_die1", 32'(dut.die1), 32'd1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_outputs("post_rst");
        end
        check("post_rst_state", 32'(dut.state), 32'(ST_READY));
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
